pipe_trace_monitor: RTL and testbench
=====================================

PIPE_TRACE_MONITOR -- requirements
Module: pipe_trace_monitor

Interface
REQ-001 SHALL have parameters CNT_W, default 32, event-counter width.
REQ-002 SHALL have parameter TRACE_DEPTH, default 16, retire-trace FIFO depth; power of 2 and at least 2.
REQ-003 SHALL have parameter N_WATCH, default 2, number of store-address watch channels.
REQ-004 SHALL have parameter DRAIN_CYC, default 1, post-halt drain cycles; at least 1.
REQ-005 SHALL have ports clk input 1, the single clock; all logic on the rising edge.
REQ-006 SHALL have port reset input 1: synchronous, active-low reset (low = reset, sampled on the rising edge of clk).
REQ-007 SHALL have inputs i_start and i_clear, each 1 bit: run request and clear request.
REQ-008 SHALL have inputs i_wb_valid 1, i_wb_pc 32 and i_wb_instr 32: the retiring instruction.
REQ-009 SHALL have inputs i_hazard_stall 1, i_cache_stall 1, i_flush 1, i_forwardA 2 and i_forwardB 2: pipeline event flags.
REQ-010 SHALL have inputs i_mem_access 1 and i_cache_hit 1: an access is in MEM and its hit status.
REQ-011 SHALL have inputs i_mem_write 1, i_mem_addr 32 and i_mem_wdata 32: the committed store.
REQ-012 SHALL have inputs i_watch_en N_WATCH and i_watch_addr N_WATCH*32: per-channel enable and byte address, channel k in bits [32k+31:32k].
REQ-013 SHALL have inputs i_halt_en 1, i_halt_val 32, i_halt_ref 32 and i_timeout CNT_W: the halt-compare source, halt reference and cycle limit.
REQ-014 SHALL have input i_trace_rd 1 and outputs o_trace_valid 1, o_trace_pc 32, o_trace_instr 32, o_trace_count clog2(TRACE_DEPTH)+1 and o_trace_ovf 1.
REQ-015 SHALL have outputs o_cycles, o_retired, o_hz_stalls, o_c_stalls, o_flushes, o_fwds, o_hits and o_misses, each CNT_W.
REQ-016 SHALL have outputs o_watch_hit N_WATCH and o_watch_data N_WATCH*32.
REQ-017 SHALL have outputs o_state 2 (IDLE=0, RUN=1, DRAIN=2, DONE=3), o_done 1 and o_timeout 1.

Function
REQ-018 SHALL implement the FSM: IDLE to RUN on i_start; RUN to DRAIN on halt match or timeout; DRAIN to DONE after DRAIN_CYC cycles; DONE holds.
REQ-019 Halt match SHALL be i_halt_en=1 and i_halt_val==i_halt_ref.
REQ-020 Timeout SHALL be i_timeout!=0 and o_cycles==i_timeout-1 while in RUN; it sets o_timeout sticky and uses the same transition.
REQ-021 If halt match and timeout occur in the same cycle, the FSM SHALL take the halt transition and SHALL NOT set o_timeout.
REQ-022 i_clear SHALL take priority over everything in any state: next state IDLE, all counters 0, FIFO emptied, all sticky flags 0 and watch data 0.
REQ-023 i_start SHALL be ignored in RUN, DRAIN and DONE.
REQ-024 Counters and captures SHALL update only in RUN and DRAIN; they SHALL be frozen in IDLE and DONE.
REQ-025 o_cycles SHALL increment every active cycle.
REQ-026 o_retired SHALL increment on i_wb_valid with an instruction other than 0x00000013 or 0x00000000.
REQ-027 o_hz_stalls, o_c_stalls and o_flushes SHALL increment once per active cycle in which their flag is high.
REQ-028 o_fwds SHALL increment by 1 per cycle in which i_forwardA!=0 or i_forwardB!=0 (not 2).
REQ-029 o_hits SHALL increment when i_mem_access, i_cache_hit and !i_cache_stall are all true.
REQ-030 o_misses SHALL increment once per miss: on i_mem_access with !i_cache_hit and an internal miss_pend flag clear. miss_pend is set by that event and cleared when i_cache_stall falls.
REQ-031 All counters SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-032 The trace FIFO SHALL push {i_wb_pc, i_wb_instr} under the o_retired increment condition.
REQ-033 The trace FIFO SHALL be first-word-fall-through: o_trace_valid = (o_trace_count!=0), head shown on o_trace_pc/o_trace_instr, popped on i_trace_rd with o_trace_valid.
REQ-034 Reads SHALL be allowed in every state; i_trace_rd when empty SHALL be a no-op.
REQ-035 A push when full without a pop SHALL drop the oldest entry, keep the count at TRACE_DEPTH and set o_trace_ovf sticky.
REQ-036 A push and pop in the same cycle when full SHALL leave count TRACE_DEPTH with no overflow.
REQ-037 A push and pop in the same cycle when empty SHALL push only.
REQ-038 Watch channel k SHALL set o_watch_hit[k] sticky and latch i_mem_wdata on active i_mem_write with i_watch_en[k] and i_mem_addr==addr[k]; the last matching store wins.
REQ-039 Multiple watch channels SHALL be able to hit on the same store.
REQ-040 o_done SHALL equal (state==DONE) and SHALL be a register output.

Reset
REQ-041 With reset low at a rising edge: state IDLE, every counter 0, FIFO empty, o_trace_ovf, o_timeout, o_watch_hit and o_watch_data all 0, miss_pend 0; reset overrides i_clear and i_start. A reset applied mid-RUN SHALL discard all captured data.

Verification
REQ-042 Start, then 10 cycles with i_hazard_stall high in 3 of them -> o_cycles=10, o_hz_stalls=3.
REQ-043 Miss with i_cache_stall high for 4 cycles, then hit -> o_misses=1, o_c_stalls=4, o_hits=1.
REQ-044 TRACE_DEPTH=16: 18 non-NOP retires with no reads -> count=16, ovf=1, head pc equals the 3rd pushed pc; a NOP retire -> not pushed.
REQ-045 Watch 0 at 32: stores 7 then 9 to 32, and 5 to 36 -> hit=01, data0=9.
REQ-046 i_halt_val==100 with i_halt_en=1, DRAIN_CYC=1 -> DRAIN, next cycle DONE, o_done=1, counters frozen; i_clear -> IDLE, all 0.
REQ-047 i_timeout=5 with no halt -> DONE after o_cycles=5+DRAIN_CYC, o_timeout=1; CNT_W=4 with 20 cycles -> o_cycles=15.

Source files
------------

// File: rtl/pipe_trace_monitor_if.sv
// Retire-trace read port of pipe_trace_monitor.
// The monitor drives the FWFT head; the consumer drives the pop.
interface pipe_trace_monitor_if #(
  parameter int TRACE_DEPTH = 16
);
  localparam int CW = $clog2(TRACE_DEPTH) + 1;

  logic          i_trace_rd;
  logic          o_trace_valid;
  logic [31:0]   o_trace_pc;
  logic [31:0]   o_trace_instr;
  logic [CW-1:0] o_trace_count;
  logic          o_trace_ovf;

  modport master (
    input  i_trace_rd,
    output o_trace_valid,
    output o_trace_pc,
    output o_trace_instr,
    output o_trace_count,
    output o_trace_ovf
  );

  modport slave (
    output i_trace_rd,
    input  o_trace_valid,
    input  o_trace_pc,
    input  o_trace_instr,
    input  o_trace_count,
    input  o_trace_ovf
  );
endinterface

// File: rtl/pipe_trace_monitor.sv
// Pipeline performance/trace monitor: event counters, retire trace
// FIFO, store-address watchpoints and a halt/timeout run controller.
module pipe_trace_monitor #(
  parameter int CNT_W       = 32,
  parameter int TRACE_DEPTH = 16,
  parameter int N_WATCH     = 2,
  parameter int DRAIN_CYC   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic                 i_clear,
  input  logic                 i_wb_valid,
  input  logic [31:0]          i_wb_pc,
  input  logic [31:0]          i_wb_instr,
  input  logic                 i_hazard_stall,
  input  logic                 i_cache_stall,
  input  logic                 i_flush,
  input  logic [1:0]           i_forwardA,
  input  logic [1:0]           i_forwardB,
  input  logic                 i_mem_access,
  input  logic                 i_cache_hit,
  input  logic                 i_mem_write,
  input  logic [31:0]          i_mem_addr,
  input  logic [31:0]          i_mem_wdata,
  input  logic [N_WATCH-1:0]   i_watch_en,
  input  logic [N_WATCH*32-1:0] i_watch_addr,
  input  logic                 i_halt_en,
  input  logic [31:0]          i_halt_val,
  input  logic [31:0]          i_halt_ref,
  input  logic [CNT_W-1:0]     i_timeout,
  pipe_trace_monitor_if.master trace,
  output logic [CNT_W-1:0]     o_cycles,
  output logic [CNT_W-1:0]     o_retired,
  output logic [CNT_W-1:0]     o_hz_stalls,
  output logic [CNT_W-1:0]     o_c_stalls,
  output logic [CNT_W-1:0]     o_flushes,
  output logic [CNT_W-1:0]     o_fwds,
  output logic [CNT_W-1:0]     o_hits,
  output logic [CNT_W-1:0]     o_misses,
  output logic [N_WATCH-1:0]   o_watch_hit,
  output logic [N_WATCH*32-1:0] o_watch_data,
  output logic [1:0]           o_state,
  output logic                 o_done,
  output logic                 o_timeout
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, nxt;
  logic          done_q;
  logic [DW-1:0] drain_cnt;
  logic          to_go;
  logic          to_flag;

  logic active;
  logic halt_hit;
  logic to_hit;
  logic drain_last;

  assign active   = (state == RUN) || (state == DRAIN);
  assign halt_hit = i_halt_en && (i_halt_val == i_halt_ref);
  assign to_hit   = (i_timeout != '0)
                 && (o_cycles == i_timeout - CNT_W'(1));
  assign drain_last = (drain_cnt == DW'(DRAIN_CYC - 1));

  always_comb begin
    nxt   = state;
    to_go = 1'b0;
    unique case (state)
      IDLE:  if (i_start) nxt = RUN;
      RUN: begin
        if (halt_hit) begin
          nxt = DRAIN;
        end else if (to_hit) begin
          nxt   = DRAIN;
          to_go = 1'b1;
        end
      end
      DRAIN: if (drain_last) nxt = DONE;
      DONE:  nxt = DONE;
      default: nxt = IDLE;
    endcase
    if (i_clear) begin
      nxt   = IDLE;
      to_go = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      drain_cnt <= '0;
      to_flag   <= 1'b0;
    end else begin
      state   <= nxt;
      done_q  <= (nxt == DONE);
      if (state == DRAIN && nxt == DRAIN)
        drain_cnt <= drain_cnt + DW'(1);
      else
        drain_cnt <= '0;
      if (i_clear)    to_flag <= 1'b0;
      else if (to_go) to_flag <= 1'b1;
    end
  end

  function automatic logic [CNT_W-1:0] sat(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction

  logic retire;
  logic miss_ev;
  logic miss_pend;
  logic stall_q;

  assign retire  = i_wb_valid && (i_wb_instr != 32'h0000_0013)
                && (i_wb_instr != 32'h0000_0000);
  assign miss_ev = i_mem_access && !i_cache_hit && !miss_pend;

  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      o_cycles    <= '0;
      o_retired   <= '0;
      o_hz_stalls <= '0;
      o_c_stalls  <= '0;
      o_flushes   <= '0;
      o_fwds      <= '0;
      o_hits      <= '0;
      o_misses    <= '0;
      miss_pend   <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      stall_q <= i_cache_stall;
      if (active) begin
        o_cycles    <= sat(o_cycles, 1'b1);
        o_retired   <= sat(o_retired, retire);
        o_hz_stalls <= sat(o_hz_stalls, i_hazard_stall);
        o_c_stalls  <= sat(o_c_stalls, i_cache_stall);
        o_flushes   <= sat(o_flushes, i_flush);
        o_fwds      <= sat(o_fwds,
                           (i_forwardA != 2'b00) || (i_forwardB != 2'b00));
        o_hits      <= sat(o_hits,
                           i_mem_access && i_cache_hit && !i_cache_stall);
        o_misses    <= sat(o_misses, miss_ev);
        if (miss_ev)                         miss_pend <= 1'b1;
        else if (stall_q && !i_cache_stall) miss_pend <= 1'b0;
      end
    end
  end

  logic [63:0]   mem [TRACE_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          push, pop, full;

  assign push = active && retire;
  assign pop  = trace.i_trace_rd && (cnt != '0);
  assign full = (cnt == CW'(TRACE_DEPTH));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {i_wb_pc, i_wb_instr};
  end

  // A full push without a pop overwrites the oldest slot in place.
  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b11: begin
          wr_ptr <= wr_ptr + AW'(1);
          rd_ptr <= rd_ptr + AW'(1);
        end
        2'b10: begin
          wr_ptr <= wr_ptr + AW'(1);
          if (full) begin
            rd_ptr <= rd_ptr + AW'(1);
            ovf    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        2'b01: begin
          rd_ptr <= rd_ptr + AW'(1);
          cnt    <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      o_watch_hit  <= '0;
      o_watch_data <= '0;
    end else if (active && i_mem_write) begin
      for (int k = 0; k < N_WATCH; k++) begin
        if (i_watch_en[k]
            && i_mem_addr == i_watch_addr[32*k +: 32]) begin
          o_watch_hit[k]          <= 1'b1;
          o_watch_data[32*k +: 32] <= i_mem_wdata;
        end
      end
    end
  end

  assign trace.o_trace_valid = (cnt != '0);
  assign trace.o_trace_pc    = mem[rd_ptr][63:32];
  assign trace.o_trace_instr = mem[rd_ptr][31:0];
  assign trace.o_trace_count = cnt;
  assign trace.o_trace_ovf   = ovf;

  assign o_state   = state;
  assign o_done    = done_q;
  assign o_timeout = to_flag;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Directed bench for pipe_trace_monitor with a trace scoreboard.
// A second instance with CNT_W=4 exercises counter saturation.
module tb_pipe_trace_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, i_start, i_clear, start2;
  logic        i_wb_valid;
  logic [31:0] i_wb_pc, i_wb_instr;
  logic        i_hazard_stall, i_cache_stall, i_flush;
  logic [1:0]  i_forwardA, i_forwardB;
  logic        i_mem_access, i_cache_hit, i_mem_write;
  logic [31:0] i_mem_addr, i_mem_wdata;
  logic [1:0]  i_watch_en;
  logic [63:0] i_watch_addr;
  logic        i_halt_en;
  logic [31:0] i_halt_val, i_halt_ref, i_timeout;

  logic [31:0] o_cycles, o_retired, o_hz_stalls, o_c_stalls;
  logic [31:0] o_flushes, o_fwds, o_hits, o_misses;
  logic [1:0]  o_watch_hit;
  logic [63:0] o_watch_data;
  logic [1:0]  o_state;
  logic        o_done, o_timeout;

  logic [3:0]  c2_cyc, c2_ret, c2_hz, c2_cs, c2_fl, c2_fw, c2_hit, c2_mis;
  logic [1:0]  c2_whit;
  logic [63:0] c2_wdata;
  logic [1:0]  c2_state;
  logic        c2_done, c2_to;

  pipe_trace_monitor_if #(.TRACE_DEPTH(16)) tif ();
  pipe_trace_monitor_if #(.TRACE_DEPTH(16)) tif2 ();

  pipe_trace_monitor dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_clear(i_clear),
    .i_wb_valid(i_wb_valid), .i_wb_pc(i_wb_pc), .i_wb_instr(i_wb_instr),
    .i_hazard_stall(i_hazard_stall), .i_cache_stall(i_cache_stall),
    .i_flush(i_flush), .i_forwardA(i_forwardA), .i_forwardB(i_forwardB),
    .i_mem_access(i_mem_access), .i_cache_hit(i_cache_hit),
    .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_watch_en(i_watch_en),
    .i_watch_addr(i_watch_addr), .i_halt_en(i_halt_en),
    .i_halt_val(i_halt_val), .i_halt_ref(i_halt_ref),
    .i_timeout(i_timeout), .trace(tif),
    .o_cycles(o_cycles), .o_retired(o_retired),
    .o_hz_stalls(o_hz_stalls), .o_c_stalls(o_c_stalls),
    .o_flushes(o_flushes), .o_fwds(o_fwds), .o_hits(o_hits),
    .o_misses(o_misses), .o_watch_hit(o_watch_hit),
    .o_watch_data(o_watch_data), .o_state(o_state),
    .o_done(o_done), .o_timeout(o_timeout)
  );

  pipe_trace_monitor #(.CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .i_start(start2), .i_clear(1'b0),
    .i_wb_valid(i_wb_valid), .i_wb_pc(i_wb_pc), .i_wb_instr(i_wb_instr),
    .i_hazard_stall(i_hazard_stall), .i_cache_stall(i_cache_stall),
    .i_flush(i_flush), .i_forwardA(i_forwardA), .i_forwardB(i_forwardB),
    .i_mem_access(i_mem_access), .i_cache_hit(i_cache_hit),
    .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_watch_en(i_watch_en),
    .i_watch_addr(i_watch_addr), .i_halt_en(1'b0),
    .i_halt_val(i_halt_val), .i_halt_ref(i_halt_ref),
    .i_timeout(4'd0), .trace(tif2),
    .o_cycles(c2_cyc), .o_retired(c2_ret), .o_hz_stalls(c2_hz),
    .o_c_stalls(c2_cs), .o_flushes(c2_fl), .o_fwds(c2_fw),
    .o_hits(c2_hit), .o_misses(c2_mis), .o_watch_hit(c2_whit),
    .o_watch_data(c2_wdata), .o_state(c2_state),
    .o_done(c2_done), .o_timeout(c2_to)
  );

  int n_vec = 0;
  int n_mis = 0;
  logic [63:0] sb [$];
  logic [63:0] exp_e;
  logic        exp_ovf;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] ins,
                        input logic rd);
    i_wb_valid     = 1'b1;
    i_wb_pc        = pc;
    i_wb_instr     = ins;
    tif.i_trace_rd = rd;
    if (rd && sb.size() != 0) exp_e = sb.pop_front();
    if (ins != 32'h0 && ins != 32'h13) begin
      if (sb.size() == 16) begin
        exp_e   = sb.pop_front();
        exp_ovf = 1'b1;
      end
      sb.push_back({pc, ins});
    end
    tick();
    i_wb_valid     = 1'b0;
    tif.i_trace_rd = 1'b0;
  endtask

  task automatic drain_chk();
    for (int g = 0; g < 20 && sb.size() != 0; g++) begin
      exp_e = sb.pop_front();
      chk("trace_pc", tif.o_trace_pc, exp_e[63:32]);
      chk("trace_instr", tif.o_trace_instr, exp_e[31:0]);
      tif.i_trace_rd = 1'b1;
      tick();
      tif.i_trace_rd = 1'b0;
    end
    chk("drained_cnt", tif.o_trace_count, 0);
    chk("drained_valid", tif.o_trace_valid, 0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    i_mem_write = 1'b1;
    i_mem_addr  = a;
    i_mem_wdata = d;
    tick();
    i_mem_write = 1'b0;
  endtask

  initial begin
    reset = 1'b0; i_start = 1'b1; i_clear = 1'b1; start2 = 1'b0;
    i_wb_valid = 0; i_wb_pc = 0; i_wb_instr = 0;
    i_hazard_stall = 0; i_cache_stall = 0; i_flush = 0;
    i_forwardA = 0; i_forwardB = 0;
    i_mem_access = 0; i_cache_hit = 0; i_mem_write = 0;
    i_mem_addr = 0; i_mem_wdata = 0;
    i_watch_en = 0; i_watch_addr = 0;
    i_halt_en = 0; i_halt_val = 0; i_halt_ref = 0; i_timeout = 0;
    tif.i_trace_rd = 0; tif2.i_trace_rd = 0;
    exp_ovf = 1'b0;
    tick(); tick();
    chk("rst_state", o_state, 0);
    chk("rst_cycles", o_cycles, 0);
    chk("rst_count", tif.o_trace_count, 0);
    chk("rst_valid", tif.o_trace_valid, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ovf", tif.o_trace_ovf, 0);
    chk("rst_whit", o_watch_hit, 0);
    chk("rst_wdata", o_watch_data, 0);
    i_start = 0; i_clear = 0; reset = 1'b1;

    i_start = 1; start2 = 1; tick(); i_start = 0; start2 = 0;
    chk("run_state", o_state, 1);
    for (int i = 0; i < 10; i++) begin
      i_hazard_stall = (i == 1 || i == 4 || i == 7);
      tick();
    end
    i_hazard_stall = 0;
    chk("cycles10", o_cycles, 10);
    chk("hz3", o_hz_stalls, 3);

    i_mem_access = 1; i_cache_hit = 0; i_cache_stall = 1;
    repeat (4) tick();
    i_cache_hit = 1; i_cache_stall = 0; tick();
    i_mem_access = 0; i_cache_hit = 0;
    chk("misses", o_misses, 1);
    chk("c_stalls", o_c_stalls, 4);
    chk("hits", o_hits, 1);

    i_forwardA = 1; i_forwardB = 2; tick();
    i_forwardA = 0; i_forwardB = 3; tick();
    i_forwardB = 0; i_flush = 1; tick(); i_flush = 0;
    chk("fwds", o_fwds, 2);
    chk("flushes", o_flushes, 1);
    repeat (2) tick();
    chk("sat_cycles", c2_cyc, 15);

    for (int i = 0; i < 18; i++)
      retire(32'h1000 + 32'(4 * i), 32'h100 + 32'(i), 1'b0);
    retire(32'h2000, 32'h13, 1'b0);
    retire(32'h2004, 32'h0, 1'b0);
    chk("full_count", tif.o_trace_count, 16);
    chk("ovf", tif.o_trace_ovf, exp_ovf);
    chk("head_pc3", tif.o_trace_pc, 32'h1008);
    chk("retired", o_retired, 18);
    drain_chk();
    tif.i_trace_rd = 1; tick(); tif.i_trace_rd = 0;
    chk("rd_empty", tif.o_trace_count, 0);

    i_watch_en = 2'b01; i_watch_addr = {32'd36, 32'd32};
    store(32, 7); store(32, 9); store(36, 5);
    chk("whit01", o_watch_hit, 2'b01);
    chk("wdata09", o_watch_data, {32'd0, 32'd9});
    i_watch_en = 2'b11; i_watch_addr = {32'd32, 32'd32};
    store(32, 32'hAA);
    chk("whit11", o_watch_hit, 2'b11);
    chk("wdata_both", o_watch_data, {32'hAA, 32'hAA});

    retire(32'h5000, 32'h55, 1'b0);
    reset = 0; i_start = 1; tick(); reset = 1; i_start = 0;
    sb.delete(); exp_ovf = 0;
    chk("mid_rst_state", o_state, 0);
    chk("mid_rst_cycles", o_cycles, 0);
    chk("mid_rst_whit", o_watch_hit, 0);
    chk("mid_rst_count", tif.o_trace_count, 0);

    i_start = 1; tick(); i_start = 0;
    repeat (3) tick();
    i_halt_en = 1; i_halt_val = 100; i_halt_ref = 100; tick();
    i_halt_en = 0;
    chk("halt_drain", o_state, 2);
    chk("halt_cycles", o_cycles, 4);
    chk("drain_done0", o_done, 0);
    tick();
    chk("done_state", o_state, 3);
    chk("done_flag", o_done, 1);
    i_hazard_stall = 1; i_start = 1; tick(); tick();
    i_hazard_stall = 0; i_start = 0;
    chk("frozen_cyc", o_cycles, 5);
    chk("frozen_hz", o_hz_stalls, 0);
    chk("done_hold", o_state, 3);
    i_clear = 1; tick(); i_clear = 0;
    chk("clr_state", o_state, 0);
    chk("clr_cycles", o_cycles, 0);
    chk("clr_done", o_done, 0);

    i_timeout = 5; i_start = 1; tick(); i_start = 0;
    for (int g = 0; g < 20 && o_state != 2'd3; g++) tick();
    chk("to_state", o_state, 3);
    chk("to_cycles", o_cycles, 6);
    chk("to_flag", o_timeout, 1);
    i_clear = 1; tick(); i_clear = 0;
    chk("to_clr", o_timeout, 0);

    i_timeout = 3; i_start = 1; tick(); i_start = 0;
    tick(); tick();
    i_halt_en = 1; tick(); i_halt_en = 0;
    chk("both_state", o_state, 2);
    chk("both_noto", o_timeout, 0);
    i_timeout = 0; i_clear = 1; tick(); i_clear = 0;

    i_start = 1; tick(); i_start = 0;
    retire(32'h3000, 32'h200, 1'b1);
    chk("pp_empty", tif.o_trace_count, 1);
    for (int i = 1; i < 16; i++)
      retire(32'h3000 + 32'(4 * i), 32'h200 + 32'(i), 1'b0);
    chk("refill", tif.o_trace_count, 16);
    retire(32'h4000, 32'h300, 1'b1);
    chk("pp_full_cnt", tif.o_trace_count, 16);
    chk("pp_full_ovf", tif.o_trace_ovf, exp_ovf);
    drain_chk();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
